// File: rtl/capture_readout_if.sv
// Capture-buffer read port and host sample stream of the capture readout block.
interface capture_readout_if #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int ADDR_WIDTH   = 10
);
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [SAMPLE_WIDTH-1:0] rd_data;
  logic [SAMPLE_WIDTH-1:0] o_data;
  logic                    o_valid;
  logic                    i_ready;
  logic                    o_last;

  modport master (
    output rd_en, rd_addr, o_data, o_valid, o_last,
    input  rd_data, i_ready
  );

  modport slave (
    input  rd_en, rd_addr, o_data, o_valid, o_last,
    output rd_data, i_ready
  );
endinterface

// File: rtl/capture_readout.sv
// Dumps the circular capture buffer to the host oldest-first once the scope stops,
// then waits for a host rearm and issues a one-cycle scope restart strobe.
//
// state   | meaning
// IDLE    | waiting for a rising edge of stopped
// READ    | read enable asserted at ptr
// CAPTURE | buffer data returns, loaded into the output register
// SEND    | sample presented to host, waiting for ready
// DONE    | all entries sent, waiting for rearm
module capture_readout #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stopped,
  input  logic [ADDR_WIDTH-1:0] i_wr_ptr,
  capture_readout_if.master     bus,
  output logic                  busy,
  output logic                  done,
  input  logic                  i_rearm,
  output logic                  o_rearm
);

  localparam logic [ADDR_WIDTH-1:0] LAST_COUNT = '1;

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND, DONE} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [ADDR_WIDTH-1:0]   count;
  logic                    stopped_d;
  logic [SAMPLE_WIDTH-1:0] data_q;
  logic                    valid_q;
  logic                    last_q;
  logic                    stop_rise;
  logic                    handshake;
  logic                    at_last;

  assign stop_rise = stopped && !stopped_d;
  assign handshake = valid_q && bus.i_ready;
  assign at_last   = (count == LAST_COUNT);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (stop_rise) state_nxt = READ;
      READ:    state_nxt = stopped ? CAPTURE : IDLE;
      CAPTURE: state_nxt = stopped ? SEND : IDLE;
      SEND: begin
        if (!stopped)      state_nxt = IDLE;
        else if (handshake) state_nxt = at_last ? DONE : READ;
      end
      DONE:    if (i_rearm) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.rd_en   = (state == READ);
    bus.rd_addr = ptr;
    busy        = (state == READ) || (state == CAPTURE) || (state == SEND);
    done        = (state == DONE);
  end

  // Abort (stopped dropping mid-dump) takes priority over a coincident handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      count     <= '0;
      stopped_d <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      o_rearm   <= 1'b0;
    end else begin
      stopped_d <= stopped;
      o_rearm   <= 1'b0;
      case (state)
        IDLE: begin
          if (stop_rise) begin
            ptr   <= i_wr_ptr;
            count <= '0;
          end
        end
        CAPTURE: begin
          if (stopped) begin
            data_q  <= bus.rd_data;
            valid_q <= 1'b1;
            last_q  <= at_last;
          end
        end
        SEND: begin
          if (!stopped || handshake) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end
          if (stopped && handshake && !at_last) begin
            ptr   <= ptr + 1'b1;
            count <= count + 1'b1;
          end
        end
        DONE: begin
          if (i_rearm) o_rearm <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;
  assign bus.o_last  = last_q;

endmodule

// File: tb/tb_capture_readout.sv
// Directed bench for capture_readout on an 8-entry buffer holding a+8'h10 at address a.
module tb_capture_readout;
  localparam int SW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          stopped;
  logic [AW-1:0] i_wr_ptr;
  logic          busy, done, i_rearm, o_rearm;

  capture_readout_if #(.SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW)) bus ();

  capture_readout #(.SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .stopped(stopped), .i_wr_ptr(i_wr_ptr),
    .bus(bus), .busy(busy), .done(done), .i_rearm(i_rearm), .o_rearm(o_rearm)
  );

  always #5 clk = ~clk;

  logic [SW-1:0] mem [8];
  logic [AW-1:0] addr_q [$];
  logic [SW-1:0] data_q [$];
  logic          last_q [$];
  int            rearm_cnt = 0;
  int            n_checks  = 0;
  int            n_fail    = 0;
  int            cyc       = 0;

  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

  always @(posedge clk) begin
    if (bus.rd_en) addr_q.push_back(bus.rd_addr);
    if (bus.o_valid && bus.i_ready) begin
      data_q.push_back(bus.o_data);
      last_q.push_back(bus.o_last);
    end
    if (o_rearm) rearm_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drops stopped for two cycles, then raises it; returns just after the edge that samples the rise.
  task automatic begin_dump(input logic [AW-1:0] p);
    stopped = 1'b0;
    step();
    step();
    i_wr_ptr = p;
    addr_q.delete();
    data_q.delete();
    last_q.delete();
    stopped = 1'b1;
    cyc = 0;
    step();
  endtask

  task automatic leave_done();
    i_rearm = 1'b1;
    step();
    i_rearm = 1'b0;
    step();
  endtask

  task automatic run_to_done(input logic [SW-1:0] stall_on, input int stall_len);
    bit stalled = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (stall_len > 0 && !stalled && bus.o_valid && bus.o_data == stall_on) begin
        stalled = 1'b1;
        bus.i_ready = 1'b0;
        repeat (stall_len) begin
          step();
          chk("stall_valid", bus.o_valid, 1);
          chk("stall_data", bus.o_data, stall_on);
          chk("stall_no_read", bus.rd_en, 0);
        end
        bus.i_ready = 1'b1;
      end else begin
        step();
      end
    end
    chk("done_reached", done, 1);
  endtask

  task automatic check_dump(input logic [AW-1:0] p0);
    chk("handshakes", data_q.size(), 8);
    chk("reads", addr_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      logic [AW-1:0] a;
      a = p0 + AW'(i);
      if (i < addr_q.size()) chk("rd_addr_seq", addr_q[i], a);
      if (i < data_q.size()) begin
        chk("data_seq", data_q[i], {5'b0, a} + 8'h10);
        chk("last_seq", last_q[i], (i == 7));
      end
    end
  endtask

  initial begin
    int r0;
    bit seen;
    for (int i = 0; i < 8; i++) mem[i] = 8'(i) + 8'h10;
    reset = 1'b1; stopped = 1'b0; i_wr_ptr = '0; i_rearm = 1'b0; bus.i_ready = 1'b0;
    repeat (3) step();
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_o_data", bus.o_data, 0);
    chk("rst_o_valid", bus.o_valid, 0);
    chk("rst_o_last", bus.o_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_o_rearm", o_rearm, 0);
    reset = 1'b0;
    step();

    // Basic dump from pointer 5
    bus.i_ready = 1'b1;
    begin_dump(3'd5);
    chk("read_rd_en", bus.rd_en, 1);
    chk("read_rd_addr", bus.rd_addr, 5);
    chk("read_busy", busy, 1);
    chk("read_o_valid", bus.o_valid, 0);
    step();
    chk("capture_o_valid", bus.o_valid, 0);
    chk("capture_rd_en", bus.rd_en, 0);
    step();
    chk("first_o_valid", bus.o_valid, 1);
    chk("first_o_data", bus.o_data, 8'h15);
    chk("first_o_last", bus.o_last, 0);
    run_to_done(8'h00, 0);
    chk("dump_cycles", cyc, 25);
    check_dump(3'd5);
    chk("done_busy", busy, 0);

    // Rearm with stopped held high
    i_rearm = 1'b1;
    step();
    chk("rearm_pulse", o_rearm, 1);
    chk("rearm_done_clr", done, 0);
    step();
    chk("rearm_pulse_end", o_rearm, 0);
    step();
    i_rearm = 1'b0;
    chk("rearm_count", rearm_cnt, 1);
    seen = 1'b0;
    repeat (10) begin
      step();
      seen |= bus.rd_en;
    end
    chk("no_retrigger", seen, 0);
    chk("idle_busy", busy, 0);

    // Backpressure on the third sample
    begin_dump(3'd5);
    run_to_done(8'h17, 4);
    chk("stall_dump_cycles", cyc, 29);
    check_dump(3'd5);

    // Pointer wrap cases
    leave_done();
    begin_dump(3'd0);
    run_to_done(8'h00, 0);
    check_dump(3'd0);
    leave_done();
    begin_dump(3'd7);
    run_to_done(8'h00, 0);
    check_dump(3'd7);

    // Abort during the fourth SEND, then a fresh dump
    leave_done();
    begin_dump(3'd2);
    for (int k = 0; k < 100 && !(data_q.size() == 3 && bus.o_valid); k++) step();
    chk("abort_at_4th", bus.o_valid, 1);
    bus.i_ready = 1'b0;
    stopped = 1'b0;
    step();
    chk("abort_o_valid", bus.o_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_o_last", bus.o_last, 0);
    repeat (3) step();
    chk("abort_handshakes", data_q.size(), 3);
    seen = 1'b0;
    foreach (last_q[i]) seen |= last_q[i];
    chk("abort_no_last", seen, 0);
    chk("abort_done", done, 0);
    bus.i_ready = 1'b1;
    begin_dump(3'd6);
    run_to_done(8'h00, 0);
    check_dump(3'd6);

    // Reset during CAPTURE
    leave_done();
    begin_dump(3'd1);
    step();
    chk("pre_reset_busy", busy, 1);
    r0 = rearm_cnt;
    reset = 1'b1;
    stopped = 1'b0;
    i_rearm = 1'b1;
    step();
    chk("mid_rst_o_valid", bus.o_valid, 0);
    chk("mid_rst_o_data", bus.o_data, 0);
    chk("mid_rst_o_last", bus.o_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_en", bus.rd_en, 0);
    chk("mid_rst_rd_addr", bus.rd_addr, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_o_rearm", o_rearm, 0);
    reset = 1'b0;
    repeat (3) step();
    i_rearm = 1'b0;
    step();
    chk("idle_rearm_ignored", rearm_cnt, r0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/capture_readout.md
Name: capture_readout

Overview:
- Read side of the analyzer's circular capture buffer.
- When the stop logic raises stopped, the block reads every buffer entry, oldest first, starting at the frozen write pointer.
- Each sample goes to the host link over a valid/ready stream, with a last flag on the final sample.
- After the dump, the block waits for a host rearm request, then pulses a scope-restart strobe.

Parameters:
SAMPLE_WIDTH, 8, width of one captured sample
ADDR_WIDTH, 10, capture buffer address width; DEPTH = 2**ADDR_WIDTH entries

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
stopped  input  1  capture halted, from stop logic; level
i_wr_ptr  input  ADDR_WIDTH  write pointer, frozen while stopped; addresses the oldest sample
rd_en  output  1  buffer read enable
rd_addr  output  ADDR_WIDTH  buffer read address
rd_data  input  SAMPLE_WIDTH  buffer read data, valid exactly 1 cycle after rd_en
o_data  output  SAMPLE_WIDTH  sample to host
o_valid  output  1  o_data valid
i_ready  input  1  host accepts o_data
o_last  output  1  marks final sample; meaningful only with o_valid
busy  output  1  dump in progress (READ/CAPTURE/SEND)
done  output  1  dump complete, awaiting rearm
i_rearm  input  1  host rearm request
o_rearm  output  1  one-cycle restart strobe to scope reset logic

Behaviour:
- Reset value of every output is 0. Internal state on reset: state=IDLE, ptr=0, count=0, stopped_d=0.
- stopped_d is a 1-cycle delayed copy of stopped. A dump starts only on a rising edge (stopped && !stopped_d), so a stopped level held after rearm never re-triggers.
- State IDLE:
  - On a rising edge of stopped: ptr<=i_wr_ptr, count<=0, go to READ.
  - All other inputs are ignored, including i_rearm.
- State READ (1 cycle):
  - rd_en=1 and rd_addr=ptr, driven combinationally from state and ptr. Then go to CAPTURE.
- State CAPTURE (1 cycle):
  - o_data<=rd_data, o_valid<=1, o_last<=(count==DEPTH-1). Then go to SEND.
- State SEND:
  - o_valid, o_data and o_last hold stable until i_ready=1.
  - On o_valid && i_ready with count==DEPTH-1: o_valid<=0, o_last<=0, go to DONE.
  - On o_valid && i_ready otherwise: o_valid<=0, ptr<=ptr+1 (wraps modulo DEPTH), count<=count+1, go to READ.
- State DONE:
  - done=1.
  - When i_rearm=1: o_rearm=1 for exactly one cycle (registered pulse), go to IDLE.
- busy=1 in READ, CAPTURE and SEND; rd_en=0 outside READ.
- Latency:
  - Rising edge of stopped sampled at edge E → READ in the cycle after E → o_valid high 2 cycles later.
  - With i_ready held high, one sample every 3 cycles.
  - A full dump takes 3*DEPTH cycles, then done.
- Arithmetic and widths:
  - ptr is ADDR_WIDTH bits and wraps naturally.
  - count is ADDR_WIDTH bits; the terminal value is DEPTH-1, so there is no overflow.
- Abort: stopped low in READ, CAPTURE or SEND → next cycle state=IDLE and o_valid, o_last, busy cleared. The host treats a missing o_last as an aborted dump.
  - stopped low in DONE: remain in DONE.
- Simultaneous events:
  - i_ready during READ or CAPTURE has no effect (o_valid is 0).
  - Reset wins over every other input.
  - A stopped rising edge coincident with reset is ignored.
- Reset mid-dump: all outputs return to 0 next cycle, no o_rearm pulse. A dump restarts only on a new rising edge of stopped.
- Exactly DEPTH handshakes occur per completed dump. Addresses run i_wr_ptr, i_wr_ptr+1, …, i_wr_ptr-1 (mod DEPTH).

Test Plan:
- Basic dump: ADDR_WIDTH=3, buffer[a]=a+8'h10, i_wr_ptr=5, stopped rises, i_ready=1 → o_data sequence 15,16,17,10,11,12,13,14; o_last only on 14; first o_valid 3 cycles after stopped sampled high; done after 24 cycles.
- Backpressure: same setup, i_ready low 4 cycles on the 3rd sample → o_data=17 held stable with o_valid=1; no address advance; sequence unchanged; exactly 8 handshakes.
- Rearm: in DONE, assert i_rearm for 3 cycles → o_rearm high exactly 1 cycle, state IDLE; stopped kept high → no second dump (rd_en stays 0).
- Wrap at zero: i_wr_ptr=0 → rd_addr 0..7; i_wr_ptr=7 → rd_addr 7,0,1,…,6; o_last on address 6.
- Abort: drop stopped during the 4th SEND → o_valid, busy at 0 next cycle, no o_last seen; new stopped rising edge → full fresh dump from the new i_wr_ptr.
- Reset mid-dump: assert reset during CAPTURE → all outputs 0 next cycle, no o_rearm; i_rearm ignored in IDLE.
